// File: rtl/rsa_codec_pkg.sv
// rsa_pkg: shared definitions for the RSA codec.
//   - default key material (K, LOGK, N, E, D, EXP_2K) for a 12-bit toy key
//   - mode encodings carried on the request channel
//   - codec FSM state encoding
package rsa_pkg;

    localparam int K_DEF      = 12;
    localparam int LOGK_DEF   = 4;
    localparam int N_DEF      = 3551;   // 53 * 67
    localparam int E_DEF      = 5;
    localparam int D_DEF      = 1373;   // E*D = 1 mod lcm-free phi(N) = 3432
    localparam int EXP_2K_DEF = 2292;   // (2^K)^2 mod N

    typedef enum logic [1:0] {
        MODE_ENC  = 2'b00,
        MODE_DEC  = 2'b01,
        MODE_CUST = 2'b10,
        MODE_RSV  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

endpackage

// File: rtl/rsa_codec_if.sv
// rsa_codec_if: request/response stream bundle of the RSA codec.
//   request : in_valid, in_ready, mode, exp_in, data_in
//   response: out_valid, out_ready, data_out, err
// modport slave is the codec side, modport master the requester side.
interface rsa_codec_if #(
    parameter int K = 12
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [K-1:0] exp_in;
    logic [K-1:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] data_out;
    logic         err;

    modport slave (
        input  in_valid, mode, exp_in, data_in, out_ready,
        output in_ready, out_valid, data_out, err
    );

    modport master (
        output in_valid, mode, exp_in, data_in, out_ready,
        input  in_ready, out_valid, data_out, err
    );
endinterface

// File: rtl/rsa_codec_mod_exp.sv
// mod_exp: Montgomery modular exponentiation z = y^x mod N (R = 2^K, N odd).
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle request, taken only when idle
//   x, y       : exponent, base (y < N)
//   z, done    : result and one-cycle completion strobe
// One bit-serial Montgomery step per cycle; exponent scanned MSB first over all K bits.
module mod_exp #(
    parameter int K      = 12,
    parameter int LOGK   = 4,
    parameter int N      = 3551,
    parameter int EXP_2K = 2292
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [K-1:0] x,
    input  logic [K-1:0] y,
    output logic [K-1:0] z,
    output logic         done
);
    typedef enum logic [2:0] {PH_IDLE, PH_CONV_Y, PH_CONV_1, PH_SQR, PH_MUL, PH_OUT} phase_e;

    localparam logic [K+1:0]  N_W   = N[K+1:0];
    localparam logic [K-1:0]  R2_K  = EXP_2K[K-1:0];
    localparam logic [LOGK:0] STEPS = K[LOGK:0];

    phase_e        phase_q, phase_d;
    logic [K+1:0]  t_q, t_d;        // partial product, always < 2N
    logic [K-1:0]  a_q, a_d;        // multiplier, consumed LSB first
    logic [K-1:0]  b_q, b_d;
    logic [K-1:0]  x_q, x_d;
    logic [K-1:0]  ym_q, ym_d;      // base in Montgomery form
    logic [K-1:0]  z_q, z_d;
    logic [LOGK:0] cnt_q, cnt_d;
    logic [LOGK-1:0] bit_q, bit_d;
    logic          done_q, done_d;
    logic [K+1:0]  sum_s;
    logic [K+1:0]  red_s;
    logic [K-1:0]  res_s;

    // Next state: a Montgomery step while cnt<K, otherwise dispatch the reduced product
    always_comb begin
        phase_d = phase_q;
        t_d     = t_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        ym_d    = ym_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        sum_s   = t_q + (a_q[0] ? {2'b00, b_q} : {(K+2){1'b0}});
        sum_s   = sum_s + (sum_s[0] ? N_W : {(K+2){1'b0}});
        red_s   = (t_q >= N_W) ? (t_q - N_W) : t_q;
        res_s   = red_s[K-1:0];
        if (phase_q == PH_IDLE) begin
            if (start) begin
                x_d     = x;
                a_d     = y;
                b_d     = R2_K;
                t_d     = '0;
                cnt_d   = '0;
                phase_d = PH_CONV_Y;
            end else begin
                phase_d = PH_IDLE;
            end
        end else if (cnt_q != STEPS) begin
            t_d   = sum_s >> 1;
            a_d   = a_q >> 1;
            cnt_d = cnt_q + (LOGK+1)'(1);
        end else begin
            t_d   = '0;
            cnt_d = '0;
            case (phase_q)
                PH_CONV_Y: begin
                    ym_d    = res_s;
                    a_d     = K'(1);
                    b_d     = R2_K;
                    phase_d = PH_CONV_1;
                end
                PH_CONV_1: begin
                    // accumulator starts at R mod N (Montgomery one)
                    a_d     = res_s;
                    b_d     = res_s;
                    bit_d   = LOGK'(K-1);
                    phase_d = PH_SQR;
                end
                PH_SQR: begin
                    a_d = res_s;
                    if (x_q[bit_q]) begin
                        b_d     = ym_q;
                        phase_d = PH_MUL;
                    end else if (bit_q == '0) begin
                        b_d     = K'(1);
                        phase_d = PH_OUT;
                    end else begin
                        b_d     = res_s;
                        bit_d   = bit_q - LOGK'(1);
                        phase_d = PH_SQR;
                    end
                end
                PH_MUL: begin
                    a_d = res_s;
                    if (bit_q == '0) begin
                        b_d     = K'(1);
                        phase_d = PH_OUT;
                    end else begin
                        b_d     = res_s;
                        bit_d   = bit_q - LOGK'(1);
                        phase_d = PH_SQR;
                    end
                end
                PH_OUT: begin
                    z_d     = res_s;
                    done_d  = 1'b1;
                    phase_d = PH_IDLE;
                end
                default: phase_d = PH_IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            ym_q    <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            ym_q    <= ym_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
        end
    end

    assign z    = z_q;
    assign done = done_q;
endmodule

// File: rtl/rsa_codec.sv
// rsa_codec: RSA encrypt/decrypt engine around mod_exp.
//   clk, rst_n : clock, async active-low reset (shared with mod_exp)
//   bus        : rsa_codec_if.slave request/response stream
//   busy       : high outside IDLE
//   op_count   : successful operations, saturating
// Operands >= N or mode 11 are rejected without touching mod_exp; a core that
// does not answer within TIMEOUT cycles is aborted. Both report err=1, data_out=0.
module rsa_codec
    import rsa_pkg::*;
#(
    parameter int K       = K_DEF,
    parameter int LOGK    = LOGK_DEF,
    parameter int N       = N_DEF,
    parameter int E       = E_DEF,
    parameter int D       = D_DEF,
    parameter int EXP_2K  = EXP_2K_DEF,
    parameter int TIMEOUT = 4*K*K+64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rsa_codec_if.slave       bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int           TW       = $clog2(TIMEOUT);
    localparam logic [K-1:0] N_K      = N[K-1:0];
    localparam logic [K-1:0] E_K      = E[K-1:0];
    localparam logic [K-1:0] D_K      = D[K-1:0];
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT-1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [K-1:0]     data_q, data_d;
    logic [K-1:0]     exp_q, exp_d;
    logic             start_q, start_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [K-1:0]     dout_q, dout_d;
    logic             err_q, err_d;
    logic             ovalid_q, ovalid_d;
    logic             iready_q, iready_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [K-1:0]     exp_sel_s;
    logic [TW-1:0]    tmo_nxt_s;
    logic [K-1:0]     z_s;
    logic             done_s;

    mod_exp #(.K(K), .LOGK(LOGK), .N(N), .EXP_2K(EXP_2K)) u_mod_exp (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_q),
        .x     (exp_q),
        .y     (data_q),
        .z     (z_s),
        .done  (done_s)
    );

    // Exponent select by request mode
    always_comb begin
        exp_sel_s = '0;
        case (mode_e'(bus.mode))
            MODE_ENC:  exp_sel_s = E_K;
            MODE_DEC:  exp_sel_s = D_K;
            MODE_CUST: exp_sel_s = bus.exp_in;
            default:   exp_sel_s = '0;
        endcase
    end

    // FSM next state and datapath updates
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        data_d    = data_q;
        exp_d     = exp_q;
        start_d   = 1'b0;
        tmo_d     = tmo_q;
        dout_d    = dout_q;
        err_d     = err_q;
        ovalid_d  = ovalid_q;
        cnt_d     = cnt_q;
        tmo_nxt_s = tmo_q + TW'(1);
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && iready_q) begin
                    data_d  = bus.data_in;
                    exp_d   = exp_sel_s;
                    mode_d  = mode_e'(bus.mode);
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (data_q >= N_K || mode_q == MODE_RSV) begin
                    dout_d   = '0;
                    err_d    = 1'b1;
                    ovalid_d = 1'b1;
                    state_d  = ST_HOLD;
                end else begin
                    start_d  = 1'b1;   // registered: high exactly while in START
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done has priority over an expiring timeout
                if (done_s) begin
                    dout_d   = z_s;
                    err_d    = 1'b0;
                    ovalid_d = 1'b1;
                    state_d  = ST_HOLD;
                end else if (tmo_nxt_s == TMO_LAST) begin
                    dout_d   = '0;
                    err_d    = 1'b1;
                    ovalid_d = 1'b1;
                    state_d  = ST_HOLD;
                end else begin
                    tmo_d    = tmo_nxt_s;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = ST_IDLE;
                    if (!err_q && cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        iready_d = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_ENC;
            data_q   <= '0;
            exp_q    <= '0;
            start_q  <= 1'b0;
            tmo_q    <= '0;
            dout_q   <= '0;
            err_q    <= 1'b0;
            ovalid_q <= 1'b0;
            iready_q <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
            exp_q    <= exp_d;
            start_q  <= start_d;
            tmo_q    <= tmo_d;
            dout_q   <= dout_d;
            err_q    <= err_d;
            ovalid_q <= ovalid_d;
            iready_q <= iready_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = iready_q;
    assign bus.out_valid = ovalid_q;
    assign bus.data_out  = dout_q;
    assign bus.err       = err_q;
    assign busy          = busy_q;
    assign op_count      = cnt_q;
endmodule

// File: tb/tb_rsa_codec.sv
// tb_rsa_codec: directed test of rsa_codec with hand-computed expectations.
// A second instance with a short TIMEOUT exercises the abort path, since its
// core cannot finish in time.
module tb_rsa_codec;
    localparam int K     = 12;
    localparam int N     = 3551;
    localparam int TMO_T = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, busy_t;
    logic [15:0] op_count, cnt_t;

    rsa_codec_if #(.K(K)) bus_m ();
    rsa_codec_if #(.K(K)) bus_t ();

    rsa_codec u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_m), .busy(busy), .op_count(op_count));
    rsa_codec #(.TIMEOUT(TMO_T)) u_dut_tmo (.clk(clk), .rst_n(rst_n), .bus(bus_t),
                                            .busy(busy_t), .op_count(cnt_t));

    always #5 clk = ~clk;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;
    int exp_cnt    = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs != exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mod_pow(input int b, input int e, input int n);
        longint r  = 1;
        longint bb = b % n;
        for (int i = 0; i < K; i++) begin
            if (e[i]) r = (r * bb) % n;
            bb = (bb * bb) % n;
        end
        return int'(r);
    endfunction

    // One full transaction on the main DUT with out_ready held high.
    task automatic run_txn(input logic [1:0] md, input logic [K-1:0] ex, input logic [K-1:0] din,
                           output logic [K-1:0] dout, output logic e, output int lat);
        @(negedge clk);
        check_val("in_ready_idle", bus_m.in_ready, 1);
        bus_m.in_valid  = 1'b1;
        bus_m.mode      = md;
        bus_m.exp_in    = ex;
        bus_m.data_in   = din;
        bus_m.out_ready = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            bus_m.in_valid = 1'b0;
            lat++;
        end while (!bus_m.out_valid && lat < 2000);
        if (!bus_m.out_valid) check_val("rsp_wait", bus_m.out_valid, 1);
        dout = bus_m.data_out;
        e    = bus_m.err;
    endtask

    task automatic txn_expect(input string tag, input logic [1:0] md, input logic [K-1:0] ex,
                              input logic [K-1:0] din, input int want);
        logic [K-1:0] d;
        logic         e;
        int           lat;
        run_txn(md, ex, din, d, e, lat);
        check_val({tag, "_data"}, d, want);
        check_val({tag, "_err"}, e, 0);
        exp_cnt++;
    endtask

    task automatic reject_expect(input string tag, input logic [1:0] md, input logic [K-1:0] din);
        logic [K-1:0] d;
        logic         e;
        int           lat;
        run_txn(md, 12'd0, din, d, e, lat);
        check_val({tag, "_lat"}, lat, 2);
        check_val({tag, "_data"}, d, 0);
        check_val({tag, "_err"}, e, 1);
        @(negedge clk);
        check_val({tag, "_cnt"}, op_count, exp_cnt);
    endtask

    initial begin
        int m, c, lat;
        bus_m.in_valid = 1'b0; bus_m.mode = 2'b00; bus_m.exp_in = '0;
        bus_m.data_in = '0;    bus_m.out_ready = 1'b1;
        bus_t.in_valid = 1'b0; bus_t.mode = 2'b00; bus_t.exp_in = '0;
        bus_t.data_in = '0;    bus_t.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_val("rst_in_ready", bus_m.in_ready, 1);
        check_val("rst_out_valid", bus_m.out_valid, 0);
        check_val("rst_data_out", bus_m.data_out, 0);
        check_val("rst_err", bus_m.err, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_op_count", op_count, 0);
        rst_n = 1'b1;

        // encrypt / decrypt known pairs
        txn_expect("enc2", 2'b00, 12'd0, 12'd2, 32);
        txn_expect("enc100", 2'b00, 12'd0, 12'd100, 492);
        @(negedge clk);
        check_val("cnt_after_enc", op_count, 2);
        txn_expect("dec492", 2'b01, 12'd0, 12'd492, 100);
        txn_expect("dec32", 2'b01, 12'd0, 12'd32, 2);

        // round trips, including range boundaries 0 and N-1
        for (int i = 0; i < 6; i++) begin
            m = (i == 0) ? 0 : (i == 1) ? N - 1 : int'($urandom_range(0, N - 1));
            c = mod_pow(m, 5, N);
            txn_expect("rt_enc", 2'b00, 12'd0, K'(m), c);
            txn_expect("rt_dec", 2'b01, 12'd0, K'(c), m);
        end

        // rejection
        reject_expect("rej_range", 2'b00, 12'd3551);
        reject_expect("rej_mode", 2'b11, 12'd5);

        // custom exponent
        txn_expect("cust1", 2'b10, 12'd1, 12'd1234, 1234);
        txn_expect("cust0", 2'b10, 12'd0, 12'd77, 1);
        @(negedge clk);
        check_val("cnt_after_cust", op_count, exp_cnt);

        // backpressure: hold result for 10 cycles while in_valid pulses
        bus_m.in_valid = 1'b1; bus_m.mode = 2'b00; bus_m.data_in = 12'd2; bus_m.out_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            bus_m.in_valid = 1'b0;
            lat++;
        end while (!bus_m.out_valid && lat < 2000);
        check_val("bp_valid", bus_m.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check_val("bp_data", bus_m.data_out, 32);
            check_val("bp_err", bus_m.err, 0);
            check_val("bp_in_ready", bus_m.in_ready, 0);
            bus_m.in_valid = i[0];
            bus_m.data_in  = 12'd7;
            @(negedge clk);
        end
        check_val("bp_still_valid", bus_m.out_valid, 1);
        bus_m.in_valid  = 1'b0;
        bus_m.out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        check_val("bp_released", bus_m.out_valid, 0);
        check_val("bp_ready_back", bus_m.in_ready, 1);
        check_val("bp_cnt", op_count, exp_cnt);
        @(negedge clk);
        check_val("bp_single_rsp", bus_m.out_valid, 0);

        // timeout on the short-TIMEOUT instance
        bus_t.in_valid = 1'b1; bus_t.mode = 2'b00; bus_t.data_in = 12'd2;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            bus_t.in_valid = 1'b0;
            lat++;
        end while (!bus_t.out_valid && lat < 2000);
        check_val("tmo_lat", lat, TMO_T + 2);
        check_val("tmo_data", bus_t.data_out, 0);
        check_val("tmo_err", bus_t.err, 1);
        @(negedge clk);
        check_val("tmo_cnt", cnt_t, 0);
        check_val("tmo_ready", bus_t.in_ready, 1);

        // reset in the middle of WAIT
        bus_m.in_valid = 1'b1; bus_m.mode = 2'b01; bus_m.data_in = 12'd492;
        @(posedge clk);
        repeat (20) begin
            @(negedge clk);
            bus_m.in_valid = 1'b0;
        end
        check_val("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_in_ready", bus_m.in_ready, 1);
        check_val("mid_rst_out_valid", bus_m.out_valid, 0);
        check_val("mid_rst_data", bus_m.data_out, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_cnt", op_count, 0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        txn_expect("post_rst", 2'b01, 12'd0, 12'd492, 100);
        @(negedge clk);
        check_val("post_rst_cnt", op_count, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end
endmodule

// File: doc/rsa_codec.md
Name: rsa_codec

Overview:
- Parametrised RSA encrypt/decrypt engine with a valid/ready stream interface on both sides.
- Wraps the existing mod_exp (Montgomery modular exponentiation) core and selects the exponent per transaction: public E, private D, or a runtime exponent.
- Validates operands and times out a hung core, reporting both conditions through an error flag.
- Holds results under backpressure and keeps a count of completed operations.

Parameters:
- K, 12: operand/modulus/exponent width in bits.
- LOGK, 4: ceil(log2(K)); passed to mod_exp.
- N, 3551: modulus; must satisfy N < 2^K.
- E, 5: public exponent.
- D, 1373: private exponent.
- EXP_2K, 2292: (2^K)^2 mod N, the Montgomery conversion constant; passed to mod_exp.
- TIMEOUT, 4*K*K+64: maximum cycles from mod_exp start to mod_exp done.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request.
- mode  in  2  00 encrypt (E), 01 decrypt (D), 10 custom exponent (exp_in), 11 reserved.
- exp_in  in  K  exponent used when mode=10.
- data_in  in  K  message or ciphertext.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- data_out  out  K  result.
- err  out  1  qualifies data_out; 1 = operation rejected or aborted.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  count of successful operations; saturates at all-ones.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; in_ready=1, out_valid=0, data_out=0, err=0, busy=0, op_count=0, timeout counter=0, mod_exp start=0.
- Accept: handshake occurs when in_valid && in_ready. On accept, data_in and the selected exponent are registered. Inputs are ignored when in_ready=0.
- in_ready = (state==IDLE), a registered state decode.
- FSM states: IDLE, CHECK, START, WAIT, HOLD.
- IDLE -> CHECK on accept.
- CHECK, single cycle:
  - If data_in >= N or mode==11: result=0, err=1, go to HOLD (rejection path, no mod_exp activity).
  - Otherwise go to START.
- START: drive mod_exp start high for exactly one cycle, clear the timeout counter, go to WAIT. mod_exp receives x = selected exponent, y = registered data.
- WAIT:
  - On mod_exp done: capture z into data_out, err=0, go to HOLD.
  - Timeout counter increments every cycle. If it reaches TIMEOUT-1 with no done: data_out=0, err=1, go to HOLD.
  - If done and timeout occur in the same cycle, done wins.
- HOLD:
  - out_valid=1; data_out and err are stable while out_ready=0.
  - On out_ready: out_valid drops next cycle and state returns to IDLE. op_count increments on this handshake only when err=0, saturating at all-ones.
- Latency, valid path: accept at cycle T -> start pulse at T+2 -> out_valid at Tdone+1, where Tdone is the cycle done is sampled high.
- Latency, rejection path: out_valid at T+2.
- No pipelining: one transaction in flight. A new accept cannot occur earlier than the cycle after the output handshake (the IDLE cycle).
- Arithmetic: the range compare is unsigned at K bits. Exponent 0 is legal and yields 1, as produced by mod_exp. data_in = 0 yields 0 for any non-zero exponent.
- mod_exp start is a one-cycle pulse only. A done that arrives outside WAIT is ignored.
- Reset mid-operation aborts the transaction with no output. mod_exp shares rst_n.

Decomposition:
- Package rsa_pkg:
  - Key parameter defaults (N, E, D, EXP_2K, K, LOGK).
  - Mode encodings MODE_ENC, MODE_DEC, MODE_CUST, MODE_RSV.
  - FSM state encoding.
- Sub-module: the existing mod_exp, instantiated once, unmodified.
- The FSM, exponent mux, timeout counter and output register live in rsa_codec; no further sub-modules.

Test Plan:
- Encrypt: mode=00, data_in=2 -> data_out=32, err=0; then data_in=100 -> data_out=492, err=0; op_count=2.
- Decrypt: mode=01, data_in=492 -> data_out=100; data_in=32 -> data_out=2. Repeat the round trip for random values in [0,3550]; every one must round-trip to its original value.
- Rejection: data_in=3551 (mode=00) -> out_valid exactly 2 cycles after accept, data_out=0, err=1, op_count unchanged. Same response for mode=11 with data_in=5.
- Custom exponent: mode=10, exp_in=1, data_in=1234 -> 1234. Then exp_in=0, data_in=77 -> 1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> data_out/err stable, in_ready=0, in_valid pulses ignored. Release -> exactly one result handshake, then in_ready=1.
- Fault and reset: force mod_exp done low -> err=1, data_out=0 at TIMEOUT+2 cycles after accept. Separately, assert rst_n low mid-WAIT -> all outputs return to reset values immediately, and the next request completes correctly.
